// File: rtl/avalon_bridge_pkg.sv
// Shared types and command-word layout for the Avalon-MM pipeline bridge.
// Command word, LSB first: byteenable, write, read, address, writedata.
package avalon_bridge_pkg;

    localparam int PENDING_W = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int off_be();
        return 0;
    endfunction

    function automatic int off_write(input int data_w);
        return be_width(data_w);
    endfunction

    function automatic int off_read(input int data_w);
        return be_width(data_w) + 1;
    endfunction

    function automatic int off_addr(input int data_w);
        return be_width(data_w) + 2;
    endfunction

    function automatic int off_data(input int data_w, input int addr_w);
        return be_width(data_w) + 2 + addr_w;
    endfunction

    function automatic int cmd_width(input int data_w, input int addr_w);
        return off_data(data_w, addr_w) + data_w;
    endfunction

endpackage

// File: rtl/avalon_bridge_sync_fifo.sv
// Single-clock show-ahead FIFO holding the bridge command words.
// DEPTH must be a power of two so the pointers wrap naturally.
module avalon_bridge_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/avalon_mm_pipeline_bridge.sv
// Avalon-MM pipeline bridge: command FIFO, registered master port with read credits,
// registered response stage. Define AVALON_BRIDGE_EOP_EN to carry endofpacket on responses.
module avalon_mm_pipeline_bridge
    import avalon_bridge_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int CMD_DEPTH   = 8,
    parameter int MAX_PENDING = 4,
    parameter int BYTE_ADDR   = 1,
    localparam int BE_W       = DATA_W / 8,
    localparam int LSB_W      = $clog2(BE_W),
    localparam int MADDR_W    = ADDR_W + 2 * BYTE_ADDR * LSB_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [ADDR_W-1:0]  slave_address,
    input  logic [BE_W-1:0]    slave_byteenable,
    input  logic               slave_read,
    input  logic               slave_write,
    input  logic [DATA_W-1:0]  slave_writedata,
    output logic               slave_waitrequest,
    output logic [DATA_W-1:0]  slave_readdata,
    output logic               slave_readdatavalid,
    output logic [MADDR_W-1:0] master_address,
    output logic [BE_W-1:0]    master_byteenable,
    output logic [DATA_W-1:0]  master_writedata,
    output logic               master_read,
    output logic               master_write,
    input  logic               master_waitrequest,
    input  logic [DATA_W-1:0]  master_readdata,
    input  logic               master_readdatavalid,
`ifdef AVALON_BRIDGE_EOP_EN
    input  logic               master_endofpacket,
    output logic               slave_endofpacket,
`endif
    output logic               rsp_unexpected_err
);

    localparam int CMD_W      = cmd_width(DATA_W, ADDR_W);
    localparam int CNT_W      = $clog2(CMD_DEPTH) + 1;
    localparam int ADDR_SHIFT = (BYTE_ADDR != 0) ? LSB_W : 0;

    state_t               state, state_nxt;
    logic [CMD_W-1:0]     push_word, head;
    logic                 fifo_full, fifo_empty, push, load;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_count_unused;
    logic [PENDING_W-1:0] pending;
    logic                 xfer_done, rd_done, credit_ok, head_ok;

    logic [ADDR_W-1:0]    head_addr;
    logic [BE_W-1:0]      head_be;
    logic [DATA_W-1:0]    head_data;
    logic                 head_rd, head_wr;

    assign push_word = {slave_writedata, slave_address, slave_read, slave_write, slave_byteenable};
    assign push      = (slave_read | slave_write) & ~fifo_full;
    assign slave_waitrequest = fifo_full;
    assign fifo_count_unused = ^fifo_count;

    avalon_bridge_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (push_word),
        .pop     (load),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign head_be   = head[off_be() +: BE_W];
    assign head_wr   = head[off_write(DATA_W)];
    assign head_rd   = head[off_read(DATA_W)];
    assign head_addr = head[off_addr(DATA_W) +: ADDR_W];
    assign head_data = head[off_data(DATA_W, ADDR_W) +: DATA_W];

    assign xfer_done = (state == ISSUE) & ~master_waitrequest;
    assign rd_done   = xfer_done & master_read;

    // A read completing this cycle already owns a credit, so count it before
    // letting the next read through on the same edge.
    assign credit_ok = ({1'b0, pending} + {{PENDING_W{1'b0}}, rd_done})
                       < (PENDING_W+1)'(MAX_PENDING);
    assign head_ok   = ~fifo_empty & (head_wr | (head_rd & credit_ok));

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (head_ok) begin
                    load      = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (~master_waitrequest) begin
                    if (head_ok) load      = 1'b1;
                    else         state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            master_read       <= 1'b0;
            master_write      <= 1'b0;
            master_address    <= '0;
            master_byteenable <= '0;
            master_writedata  <= '0;
        end else if (load) begin
            master_read       <= head_rd;
            master_write      <= head_wr;
            master_address    <= MADDR_W'(head_addr) << ADDR_SHIFT;
            master_byteenable <= head_be;
            master_writedata  <= head_data;
        end else if (xfer_done) begin
            master_read  <= 1'b0;
            master_write <= 1'b0;
        end
    end

    // Outstanding-read credits; a response with nothing pending is flagged, not counted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending            <= '0;
            rsp_unexpected_err <= 1'b0;
        end else begin
            case ({rd_done, master_readdatavalid})
                2'b10: pending <= pending + 1'b1;
                2'b01: begin
                    if (pending == '0) rsp_unexpected_err <= 1'b1;
                    else               pending <= pending - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef AVALON_BRIDGE_EOP_EN
    localparam int RSP_W = DATA_W + 1;
    logic [RSP_W-1:0] rsp_in, rsp_q;
    assign rsp_in = {master_endofpacket, master_readdata};
    assign {slave_endofpacket, slave_readdata} = rsp_q;
`else
    localparam int RSP_W = DATA_W;
    logic [RSP_W-1:0] rsp_in, rsp_q;
    assign rsp_in = master_readdata;
    assign slave_readdata = rsp_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rsp_q               <= '0;
            slave_readdatavalid <= 1'b0;
        end else begin
            slave_readdatavalid <= master_readdatavalid;
            if (master_readdatavalid) rsp_q <= rsp_in;
        end
    end

endmodule

// File: tb/tb_avalon_mm_pipeline_bridge.sv
// Self-checking bench: vector table plus directed sequences, with command and
// response scoreboards checked on the falling edge.
module tb_avalon_mm_pipeline_bridge;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [8:0]  slave_address;
    logic [3:0]  slave_byteenable;
    logic        slave_read, slave_write;
    logic [31:0] slave_writedata;
    logic        slave_waitrequest;
    logic [31:0] slave_readdata;
    logic        slave_readdatavalid;
    logic [12:0] master_address;
    logic [3:0]  master_byteenable;
    logic [31:0] master_writedata;
    logic        master_read, master_write;
    logic        master_waitrequest;
    logic [31:0] master_readdata;
    logic        master_readdatavalid;
    logic        rsp_unexpected_err;

    always #5 clk = ~clk;

    avalon_mm_pipeline_bridge #(
        .DATA_W(32), .ADDR_W(9), .CMD_DEPTH(4), .MAX_PENDING(2), .BYTE_ADDR(1)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .slave_address        (slave_address),
        .slave_byteenable     (slave_byteenable),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_writedata      (slave_writedata),
        .slave_waitrequest    (slave_waitrequest),
        .slave_readdata       (slave_readdata),
        .slave_readdatavalid  (slave_readdatavalid),
        .master_address       (master_address),
        .master_byteenable    (master_byteenable),
        .master_writedata     (master_writedata),
        .master_read          (master_read),
        .master_write         (master_write),
        .master_waitrequest   (master_waitrequest),
        .master_readdata      (master_readdata),
        .master_readdatavalid (master_readdatavalid),
        .rsp_unexpected_err   (rsp_unexpected_err)
    );

    typedef struct {
        logic        rd;
        logic [12:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic        rd;
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] data;
        logic [12:0] exp_addr;
    } vec_t;

    cmd_t        cmd_q[$];
    logic [31:0] rsp_q[$];
    int total = 0, bad = 0;
    int n_done = 0, n_rd = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboards: master-side transfers and slave-side responses.
    always @(negedge clk) begin : monitor
        cmd_t e;
        if (reset_n && (master_read || master_write) && !master_waitrequest) begin
            n_done++;
            if (master_read) n_rd++;
            chk("cmd_expected", 64'(cmd_q.size() != 0), 64'(1));
            if (cmd_q.size() != 0) begin
                e = cmd_q.pop_front();
                chk("cmd_rd",   64'(master_read),       64'(e.rd));
                chk("cmd_wr",   64'(master_write),      64'(!e.rd));
                chk("cmd_addr", 64'(master_address),    64'(e.addr));
                chk("cmd_be",   64'(master_byteenable), 64'(e.be));
                if (!e.rd) chk("cmd_data", 64'(master_writedata), 64'(e.data));
            end
        end
        if (slave_readdatavalid) begin
            chk("rsp_expected", 64'(rsp_q.size() != 0), 64'(1));
            if (rsp_q.size() != 0) chk("rsp_sb_data", 64'(slave_readdata), 64'(rsp_q.pop_front()));
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic slave_cmd(input logic rd, input logic [8:0] a, input logic [3:0] be,
                             input logic [31:0] d, input logic [12:0] exp_a);
        bit acc = 1'b0;
        slave_read       = rd;
        slave_write      = !rd;
        slave_address    = a;
        slave_byteenable = be;
        slave_writedata  = rd ? 32'h0 : d;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (!slave_waitrequest) begin
                acc = 1'b1;
                cmd_q.push_back('{rd, exp_a, be, d});
            end
            @(posedge clk); #1;
        end
        slave_read  = 1'b0;
        slave_write = 1'b0;
        chk("slave_accept", 64'(acc), 64'(1));
    endtask

    task automatic wr(input logic [8:0] a, input logic [31:0] d);
        slave_cmd(1'b0, a, 4'hF, d, 13'({a, 2'b00}));
    endtask

    task automatic rd(input logic [8:0] a);
        slave_cmd(1'b1, a, 4'hF, 32'h0, 13'({a, 2'b00}));
    endtask

    task automatic send_rsp(input logic [31:0] d);
        master_readdatavalid = 1'b1;
        master_readdata      = d;
        rsp_q.push_back(d);
        @(posedge clk); #1;
        master_readdatavalid = 1'b0;
        chk("rsp_valid_next", 64'(slave_readdatavalid), 64'(1));
        chk("rsp_data_next",  64'(slave_readdata),      64'(d));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   base, base_rd;

        vecs[0] = '{1'b0, 9'h000, 4'hF, 32'h0000_0001, 13'h0000};
        vecs[1] = '{1'b0, 9'h1FF, 4'h1, 32'hA5A5_A5A5, 13'h07FC};
        vecs[2] = '{1'b1, 9'h010, 4'hF, 32'h0000_0000, 13'h0040};
        vecs[3] = '{1'b0, 9'h0AA, 4'h6, 32'h1234_0000, 13'h02A8};
        vecs[4] = '{1'b1, 9'h155, 4'hF, 32'h0000_0000, 13'h0554};
        vecs[5] = '{1'b0, 9'h100, 4'h8, 32'hFFFF_FFFF, 13'h0400};

        reset_n = 1'b0;
        slave_address = '0; slave_byteenable = '0; slave_read = 1'b0; slave_write = 1'b0;
        slave_writedata = '0; master_waitrequest = 1'b0; master_readdata = '0;
        master_readdatavalid = 1'b0;
        cycles(3);

        chk("rst_master_read",  64'(master_read),         64'(0));
        chk("rst_master_write", 64'(master_write),        64'(0));
        chk("rst_master_addr",  64'(master_address),      64'(0));
        chk("rst_master_wdata", 64'(master_writedata),    64'(0));
        chk("rst_rdv",          64'(slave_readdatavalid), 64'(0));
        chk("rst_rdata",        64'(slave_readdata),      64'(0));
        chk("rst_waitreq",      64'(slave_waitrequest),   64'(0));
        chk("rst_err",          64'(rsp_unexpected_err),  64'(0));
        chk("rst_pending",      64'(dut.pending),         64'(0));
        reset_n = 1'b1;
        cycles(1);

        // Two-cycle command latency, held under stall.
        master_waitrequest = 1'b1;
        wr(9'h005, 32'hDEADBEEF);
        chk("lat_not_yet", 64'(master_write), 64'(0));
        cycles(1);
        chk("lat_write",  64'(master_write),     64'(1));
        chk("lat_addr",   64'(master_address),   64'(13'h014));
        chk("lat_wdata",  64'(master_writedata), 64'(32'hDEADBEEF));
        cycles(2);
        chk("hold_write", 64'(master_write),     64'(1));
        chk("hold_addr",  64'(master_address),   64'(13'h014));
        master_waitrequest = 1'b0;
        cycles(1);
        chk("lat_done",   64'(master_write),     64'(0));

        // Vector table, back to back.
        base = n_done;
        for (int i = 0; i < 6; i++)
            slave_cmd(vecs[i].rd, vecs[i].addr, vecs[i].be, vecs[i].data, vecs[i].exp_addr);
        cycles(3);
        chk("table_drain", 64'(n_done - base), 64'(6));
        chk("table_pending", 64'(dut.pending), 64'(2));
        send_rsp(32'hC0DE0001);
        send_rsp(32'hC0DE0002);
        chk("table_pending0", 64'(dut.pending), 64'(0));

        // Fill the FIFO behind a stalled master.
        master_waitrequest = 1'b1;
        base = n_done;
        for (int i = 0; i < 4; i++) wr(9'(9'h020 + i), 32'h100 + i);
        chk("fifo_not_full", 64'(slave_waitrequest), 64'(0));
        wr(9'h024, 32'h104);
        chk("fifo_full", 64'(slave_waitrequest), 64'(1));
        fork
            wr(9'h025, 32'h105);
            begin
                cycles(3);
                chk("fifo_full_hold", 64'(slave_waitrequest), 64'(1));
                master_waitrequest = 1'b0;
            end
        join
        cycles(6);
        chk("fifo_drain", 64'(n_done - base), 64'(6));
        chk("fifo_empty_wr", 64'(slave_waitrequest), 64'(0));

        // Credit limit blocks the third read and the write behind it.
        base = n_done; base_rd = n_rd;
        rd(9'h030); rd(9'h031); rd(9'h032); wr(9'h033, 32'h33);
        cycles(5);
        chk("credit_reads",   64'(n_rd - base_rd), 64'(2));
        chk("credit_blocked", 64'(n_done - base),  64'(2));
        chk("credit_strobe",  64'(master_read),    64'(0));
        chk("credit_pending", 64'(dut.pending),    64'(2));
        send_rsp(32'h12345678);
        cycles(1);
        chk("rsp_one_cycle", 64'(slave_readdatavalid), 64'(0));
        cycles(4);
        chk("credit_reads3", 64'(n_rd - base_rd), 64'(3));
        chk("credit_all",    64'(n_done - base),  64'(4));
        send_rsp(32'h0000AAAA);
        send_rsp(32'h0000BBBB);
        chk("credit_pending0", 64'(dut.pending), 64'(0));

        // Read completion and response on the same edge.
        rd(9'h040);
        cycles(3);
        chk("same_pre", 64'(dut.pending), 64'(1));
        master_waitrequest = 1'b1;
        rd(9'h041);
        cycles(1);
        chk("same_held", 64'(master_read), 64'(1));
        master_waitrequest   = 1'b0;
        master_readdatavalid = 1'b1;
        master_readdata      = 32'hAAAA5555;
        rsp_q.push_back(32'hAAAA5555);
        cycles(1);
        master_readdatavalid = 1'b0;
        chk("same_pending", 64'(dut.pending), 64'(1));
        send_rsp(32'h5555AAAA);
        chk("same_pending0", 64'(dut.pending), 64'(0));

        // Unexpected response is sticky.
        chk("err_before", 64'(rsp_unexpected_err), 64'(0));
        send_rsp(32'hBAD0BAD0);
        chk("err_set",     64'(rsp_unexpected_err), 64'(1));
        chk("err_pending", 64'(dut.pending),        64'(0));
        cycles(5);
        chk("err_sticky",  64'(rsp_unexpected_err), 64'(1));

        // Reset with queued commands and outstanding reads.
        rd(9'h060); rd(9'h061);
        cycles(3);
        master_waitrequest = 1'b1;
        wr(9'h070, 32'h70); wr(9'h071, 32'h71); wr(9'h072, 32'h72);
        chk("pre_rst_pending", 64'(dut.pending), 64'(2));
        reset_n = 1'b0;
        cycles(1);
        cmd_q.delete();
        chk("mid_rst_read",    64'(master_read),        64'(0));
        chk("mid_rst_write",   64'(master_write),       64'(0));
        chk("mid_rst_pending", 64'(dut.pending),        64'(0));
        chk("mid_rst_waitreq", 64'(slave_waitrequest),  64'(0));
        chk("mid_rst_err",     64'(rsp_unexpected_err), 64'(0));
        reset_n = 1'b1;
        master_waitrequest = 1'b0;
        base = n_done;
        cycles(4);
        chk("post_rst_idle", 64'(n_done - base), 64'(0));
        send_rsp(32'h0BAD0BAD);
        chk("post_rst_err", 64'(rsp_unexpected_err), 64'(1));

        cycles(2);
        chk("cmd_sb_empty", 64'(cmd_q.size()), 64'(0));
        chk("rsp_sb_empty", 64'(rsp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
